aes_encipher_round_ctrl: RTL and testbench
==========================================

// Module: aes_encipher_round_ctrl
// PURPOSE
//  Iterative AES encipher datapath + control: InitialRound, N main rounds, final round (no MixColumns).
//  Shares four forward aes_sbox instances across the state, one 32-bit word per cycle.
//  Requests round keys by address from the key memory and returns ciphertext via a next/ready handshake.
//  Sits alongside the decipher datapath in the core; top-level mux selects on encdec.
// PARAMETERS
//  NR_128  10  round count when keylen=0 (AES-128)
//  NR_256  14  round count when keylen=1 (AES-256)
// PORTS
//  clk             in   1    single clock, all state rising-edge
//  reset           in   1    synchronous, active-high reset
//  next            in   1    start request, sampled only when ready=1
//  keylen          in   1    0=AES-128, 1=AES-256; latched on accept
//  block           in   128  plaintext, byte 0 at [127:120]; latched on accept
//  round_key       in   128  key for round_key_addr, valid same cycle (combinational key memory)
//  round_key_addr  out  4    round index requested
//  new_block       out  128  ciphertext; held until next accept
//  ready           out  1    1=idle/result valid, 0=busy
// BEHAVIOUR
//  Reset: ready=1, new_block=0, round_key_addr=0, state=IDLE, round_ctr=0, sword_ctr=0.
//  FSM: IDLE -> INIT -> SBOX(x4, sword_ctr 0..3) -> MIX|FINAL -> SBOX... ; FINAL -> IDLE.
//  IDLE: next=1 -> latch block into block_reg, latch keylen, ready<=0, round_ctr<=0, go INIT.
//  INIT: block_reg <= block_reg ^ round_key (addr 0); round_ctr<=1; go SBOX.
//  SBOX: word sword_ctr of block_reg through 4 sboxes, written back in place; ctr wraps 3->0;
//        at sword_ctr=3 go MIX if round_ctr<N else FINAL.
//  MIX: block_reg <= MixColumns(ShiftRows(block_reg)) ^ round_key; round_ctr++; go SBOX.
//  FINAL: block_reg <= ShiftRows(block_reg) ^ round_key; new_block<=same value; ready<=1; go IDLE.
//  round_key_addr = round_ctr (comb); 0 in IDLE/INIT; range 0..N.
//  ShiftRows: row r rotated left r bytes; MixColumns over GF(2^8), poly 0x11b, xtime on bit7.
//  Latency: ready rises exactly 1+5N edges after accepting edge: 51 (AES-128), 71 (AES-256).
//  ready low for whole op; next while busy ignored (no queueing); block/keylen changes while busy ignored.
//  next held high in IDLE after completion starts a new op on next edge (back-to-back; ready high 1 cycle).
//  new_block not cleared at accept; stays previous ciphertext until FINAL overwrites.
//  reset mid-op: abort at the edge, return to reset values; no partial result visible.
//  keylen latched; round_ctr 4 bits, never exceeds N.
// CONFIGURATION
//  AES_ENC_FAST_SBOX_EN defined: 16 sbox instances; SBOX state is one cycle (sword_ctr unused, held 0);
//    latency 1+2N edges: 21 (AES-128), 29 (AES-256). Results bit-identical.
//  Undefined: 4 shared sboxes, word-serial, latency 1+5N as above.
// TESTING
//  Bench models key memory: expanded FIPS-197 schedule indexed by round_key_addr, comb response.
//  T1 reset: after reset ready=1, new_block=0, round_key_addr=0; next=0 for 10 cycles -> no change.
//  T2 AES-128: key 000102..0f, block 00112233445566778899aabbccddeeff, next 1 cycle
//     -> ready=0 next cycle, ready=1 after 51 edges, new_block=69c4e0d86a7b0430d8cdb78070b4c55a.
//  T3 AES-256: key 000102..1f, same block, keylen=1 -> 71 edges, new_block=8ea2b7ca516745bfeafc49904b496089.
//  T4 next pulsed and block changed at cycle 20 of T2 op -> result/latency unchanged; addr seq 0,1..10.
//  T5 reset asserted at cycle 30 of T3 op -> next edge ready=1, new_block=0; then T2 rerun passes.
//  T6 with AES_ENC_FAST_SBOX_EN: rerun T2/T3 -> same ciphertexts at 21 and 29 edges.

Source files
------------

// File: rtl/aes_encipher_round_ctrl.sv
// aes_encipher_round_ctrl: iterative AES-128/256 encipher datapath with round/key-address control.
// Define AES_ENC_FAST_SBOX_EN for 16 parallel sboxes (single-cycle SubBytes); default is 4 shared word-serial sboxes.
module aes_sbox (
   input  logic [7:0] plain,
   output logic [7:0] sub
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   // inverse as x^254 via square-and-multiply chain (0 maps to 0)
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = x;
      for (int i = 0; i < 6; i++) v = gmul(gmul(v, v), x);
      v = gmul(v, v);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction
   assign sub = sbox(plain);
endmodule

module aes_encipher_round_ctrl #(
   parameter int NR_128 = 10,
   parameter int NR_256 = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   input  logic [127:0] block,
   input  logic [127:0] round_key,
   output logic [3:0]   round_key_addr,
   output logic [127:0] new_block,
   output logic         ready
);
   typedef enum logic [2:0] {IDLE, INIT, SBOX, MIX, FINAL} state_t;
   state_t state, state_nxt;
   logic [127:0] block_reg, sub_block, sr_block;
   logic [3:0] round_ctr, nr;
   logic [1:0] sword_ctr;
   logic keylen_reg, last_sword;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [127:0] shift_rows(input logic [127:0] b);
      logic [127:0] s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[127-8*(4*c+r) -: 8] = b[127-8*(4*((c+r)%4)+r) -: 8];
      return s;
   endfunction
   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction
   function automatic logic [127:0] mix_columns(input logic [127:0] b);
      logic [127:0] m;
      for (int c = 0; c < 4; c++) m[127-32*c -: 32] = mix_col(b[127-32*c -: 32]);
      return m;
   endfunction

`ifdef AES_ENC_FAST_SBOX_EN
   localparam logic [1:0] SWORD_STEP = 2'd0;
   localparam logic [1:0] SWORD_LAST = 2'd0;
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (.plain(block_reg[127-8*i -: 8]), .sub(sub_block[127-8*i -: 8]));
   end
`else
   localparam logic [1:0] SWORD_STEP = 2'd1;
   localparam logic [1:0] SWORD_LAST = 2'd3;
   logic [31:0] sword, sword_sub;
   assign sword = block_reg[127-32*sword_ctr -: 32];
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (.plain(sword[31-8*i -: 8]), .sub(sword_sub[31-8*i -: 8]));
   end
   always_comb begin
      sub_block = block_reg;
      sub_block[127-32*sword_ctr -: 32] = sword_sub;
   end
`endif

   assign last_sword = sword_ctr == SWORD_LAST;
   assign nr = keylen_reg ? 4'(NR_256) : 4'(NR_128);
   assign sr_block = shift_rows(block_reg);

   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nxt;

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = next ? INIT : IDLE;
         INIT:    state_nxt = SBOX;
         SBOX:    state_nxt = !last_sword ? SBOX : (round_ctr < nr ? MIX : FINAL);
         MIX:     state_nxt = SBOX;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = state == IDLE;
      round_key_addr = round_ctr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         block_reg  <= '0;
         new_block  <= '0;
         round_ctr  <= '0;
         sword_ctr  <= '0;
         keylen_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: if (next) begin
               block_reg  <= block;
               keylen_reg <= keylen;
               round_ctr  <= '0;
            end
            INIT: begin
               block_reg <= block_reg ^ round_key;
               round_ctr <= 4'd1;
            end
            SBOX: begin
               block_reg <= sub_block;
               sword_ctr <= sword_ctr + SWORD_STEP;
            end
            MIX: begin
               block_reg <= mix_columns(sr_block) ^ round_key;
               round_ctr <= round_ctr + 4'd1;
            end
            FINAL: begin
               block_reg <= sr_block ^ round_key;
               new_block <= sr_block ^ round_key;
               round_ctr <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_encipher_round_ctrl.sv
// tb_aes_encipher_round_ctrl: randomized and known-answer checks against a byte-matrix AES model.
module tb_aes_encipher_round_ctrl;
`ifdef AES_ENC_FAST_SBOX_EN
   localparam int K = 2;
`else
   localparam int K = 5;
`endif
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk = 1'b0;
   logic reset, next, keylen, ready;
   logic [127:0] block, round_key, new_block;
   logic [3:0] round_key_addr;
   logic [127:0] rk [0:15];
   logic [7:0] sb [0:255];
   logic [127:0] last_ct;
   int total = 0, bad = 0;

   always #5 clk = ~clk;
   assign round_key = rk[round_key_addr];

   aes_encipher_round_ctrl dut (
      .clk(clk), .reset(reset), .next(next), .keylen(keylen), .block(block),
      .round_key(round_key), .round_key_addr(round_key_addr), .new_block(new_block), .ready(ready)
   );

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (a != 0 && gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[a] = s;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic set_key(input logic [255:0] key, input bit kl);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0] rc;
      int nk, nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
      logic [7:0] s [0:3][0:3];
      logic [7:0] t [0:3][0:3];
      logic [127:0] out, kk;
      kk = rk[0];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ kk[127-8*(4*c+r) -: 8];
      for (int n = 1; n <= nr; n++) begin
         kk = rk[n];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = (n < nr ? gm(t[r][c], 8'h02) ^ gm(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]
                                 : t[r][c]) ^ kk[127-8*(4*c+r) -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) out[127-8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   // one operation; optional busy-time disturbance or mid-op reset at a given edge count
   task automatic run_op(input logic [127:0] pt, input bit kl, input logic [127:0] exp_ct,
                         input int disturb_at, input int reset_at, input string name);
      int nr, lat, cyc;
      int addrs[$];
      bit done, ok;
      nr = kl ? 14 : 10;
      lat = 1 + K * nr;
      @(negedge clk);
      block = pt; keylen = kl; next = 1'b1;
      @(posedge clk); #1;
      next = 1'b0;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL %s_busy ready=%b want 0", name, ready); end
      addrs.push_back(int'(round_key_addr));
      cyc = 0; done = 0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         next = cyc == disturb_at;
         block = cyc == disturb_at ? ~pt : pt;
         keylen = cyc == disturb_at ? ~kl : kl;
         reset = cyc == reset_at;
         @(posedge clk); #1;
         cyc++;
         if (reset) begin
            reset = 1'b0;
            total++;
            if (ready !== 1'b1 || new_block !== '0 || round_key_addr !== 4'd0) begin
               bad++;
               $display("FAIL %s_abort ready=%b new_block=%h addr=%0d want 1/0/0", name, ready, new_block, round_key_addr);
            end
            last_ct = '0;
            return;
         end
         if (cyc == 3) begin
            total++;
            if (new_block !== last_ct) begin bad++; $display("FAIL %s_hold new_block=%h want %h", name, new_block, last_ct); end
         end
         if (ready) done = 1;
         else if (int'(round_key_addr) != addrs[$]) addrs.push_back(int'(round_key_addr));
      end
      total++;
      if (cyc != lat) begin bad++; $display("FAIL %s_latency edges=%0d want %0d", name, cyc, lat); end
      total++;
      if (new_block !== exp_ct) begin bad++; $display("FAIL %s_ct got=%h want=%h", name, new_block, exp_ct); end
      ok = addrs.size() == nr + 1;
      for (int i = 0; i < addrs.size(); i++) if (addrs[i] != i) ok = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL %s_addr_seq count=%0d last=%0d want 0..%0d", name, addrs.size(), addrs[$], nr); end
      last_ct = exp_ct;
   endtask

   task automatic test_reset();
      reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      last_ct = '0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if (ready !== 1'b1 || new_block !== '0 || round_key_addr !== 4'd0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d ready=%b new_block=%h addr=%0d want 1/0/0", i, ready, new_block, round_key_addr);
         end
      end
   endtask

   task automatic test_aes128();
      set_key(K1, 1'b0);
      run_op(PT, 1'b0, CT1, -1, -1, "aes128");
   endtask

   task automatic test_aes256();
      set_key(K2, 1'b1);
      run_op(PT, 1'b1, CT2, -1, -1, "aes256");
   endtask

   task automatic test_busy_ignored();
      set_key(K1, 1'b0);
      run_op(PT, 1'b0, CT1, 20, -1, "busy_ignored");
   endtask

   task automatic test_reset_mid_op();
      set_key(K2, 1'b1);
      run_op(PT, 1'b1, CT2, -1, K == 5 ? 30 : 15, "reset_mid");
      set_key(K1, 1'b0);
      run_op(PT, 1'b0, CT1, -1, -1, "after_reset");
   endtask

   task automatic test_random();
      logic [255:0] key;
      logic [127:0] pt;
      bit kl;
      for (int n = 0; n < 6; n++) begin
         kl = 1'($urandom_range(1));
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt = {$urandom, $urandom, $urandom, $urandom};
         set_key(key, kl);
         run_op(pt, kl, aes_ref(pt, kl ? 14 : 10), -1, -1, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] p1, p2, e1, e2;
      int cyc, lat;
      set_key({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0);
      p1 = {$urandom, $urandom, $urandom, $urandom};
      p2 = {$urandom, $urandom, $urandom, $urandom};
      e1 = aes_ref(p1, 10);
      e2 = aes_ref(p2, 10);
      lat = 1 + K * 10;
      @(negedge clk); block = p1; keylen = 1'b0; next = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); block = p2;
      cyc = 1;
      @(posedge clk); #1;
      while (!ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
      total++;
      if (cyc != lat || new_block !== e1) begin
         bad++; $display("FAIL b2b_first edges=%0d want %0d got=%h want=%h", cyc, lat, new_block, e1);
      end
      @(posedge clk); #1;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL b2b_restart ready=%b want 0", ready); end
      @(negedge clk); next = 1'b0;
      cyc = 1;
      @(posedge clk); #1;
      while (!ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
      total++;
      if (cyc != lat || new_block !== e2) begin
         bad++; $display("FAIL b2b_second edges=%0d want %0d got=%h want=%h", cyc, lat, new_block, e2);
      end
      last_ct = e2;
   endtask

   initial begin
      reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
      for (int r = 0; r < 16; r++) rk[r] = '0;
      build_sbox();
      test_reset();
      test_aes128();
      test_aes256();
      test_busy_ignored();
      test_reset_mid_op();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
